gmii_tx_arbiter: RTL and testbench

Sequences and shares the single GMII transmit path between the ARP transmit engine and the UDP transmit engine. Accepts level requests from both engines, issues a one-cycle start pulse to the winner, and forwards that engine's `tx_en`/`txd` to the PHY-side output. It enforces the Ethernet inter-frame gap and recovers from an engine that never signals done. It sits between `arp_tx`/`udp_tx` and the single-to-double-edge output stage, in the `gmii_txc` domain.

---
 rtl/eth_tx_pkg.sv | 24 ++
 rtl/gmii_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_gmii_tx_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkg.sv
// Shared types and default constants for the GMII transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package eth_tx_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2,
        ST_IFG   = 2'd3
    } tx_state_t;

    // Owner of the transmit path; this encoding is visible on the owner port.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_ARP  = 2'b01,
        OWN_UDP  = 2'b10
    } tx_owner_t;

    localparam int ETH_IFG_CYC    = 12;
    localparam int ETH_TX_TIMEOUT = 2048;

endpackage

// File: rtl/gmii_tx_arbiter.sv
// Shares one GMII transmit path between the ARP and UDP transmit engines (round-robin on ties).
// Latency: request in IDLE -> start pulse next cycle; engine byte -> gmii_* one cycle later.
// Backpressure: none on the byte stream; engines hold a level request until their start pulse.
//
// Ports:
//   gmii_txc, rst                       clock, asynchronous active-high reset
//   arp_req/udp_req                     level requests, sampled only in IDLE
//   arp_start/udp_start                 one-cycle grant pulse to the winning engine
//   arp_done/udp_done                   end-of-frame pulse; only the owner's is honoured
//   arp_gmii_tx_en/txd, udp_gmii_tx_en/txd  engine byte streams
//   gmii_tx_en, gmii_txd                registered muxed stream; txd is 0 while tx_en is 0
//   owner                               00 none, 01 ARP, 10 UDP
//   busy                                high outside IDLE
//   timeout_err                         one-cycle pulse when a frame is aborted
module gmii_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int IFG_CYC     = ETH_IFG_CYC,
    parameter int TIMEOUT_CYC = ETH_TX_TIMEOUT,
    parameter int CNT_W       = 12
) (
    input  logic       gmii_txc,
    input  logic       rst,
    input  logic       arp_req,
    input  logic       udp_req,
    output logic       arp_start,
    output logic       udp_start,
    input  logic       arp_done,
    input  logic       udp_done,
    input  logic       arp_gmii_tx_en,
    input  logic [7:0] arp_gmii_txd,
    input  logic       udp_gmii_tx_en,
    input  logic [7:0] udp_gmii_txd,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] IFG_LAST     = CNT_W'(IFG_CYC);

    tx_state_t        state_q, state_d;
    tx_owner_t        owner_q, owner_d;
    tx_owner_t        last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_d;

    logic             mux_en;
    logic [7:0]       mux_txd;
    logic             owner_done;

    // Select the owner's stream and done. Outside XFER the mux is held at
    // zero, which is what drains gmii_tx_en low during the inter-frame gap.
    always_comb begin
        mux_en     = 1'b0;
        mux_txd    = '0;
        owner_done = 1'b0;
        if (state_q == ST_XFER) begin
            case (owner_q)
                OWN_ARP: begin
                    mux_en     = arp_gmii_tx_en;
                    mux_txd    = arp_gmii_txd;
                    owner_done = arp_done;
                end
                OWN_UDP: begin
                    mux_en     = udp_gmii_tx_en;
                    mux_txd    = udp_gmii_txd;
                    owner_done = udp_done;
                end
                default: ;
            endcase
        end
        if (!mux_en) begin
            mux_txd = '0;
        end
    end

    // Next-state logic. One counter is reused: XFER timeout, then IFG length.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arp_req && udp_req) begin
                    // Tie: the engine not served last wins.
                    owner_d = (last_owner_q == OWN_ARP) ? OWN_UDP : OWN_ARP;
                    state_d = ST_START;
                end else if (arp_req) begin
                    owner_d = OWN_ARP;
                    state_d = ST_START;
                end else if (udp_req) begin
                    owner_d = OWN_UDP;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Done is not looked at here; the engine has not sent a byte yet.
                state_d = ST_XFER;
                cnt_d   = '0;
            end
            ST_XFER: begin
                if (owner_done) begin
                    state_d      = ST_IFG;
                    last_owner_d = owner_q;
                    cnt_d        = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d      = ST_IFG;
                    last_owner_d = owner_q;
                    cnt_d        = '0;
                    timeout_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IFG: begin
                // IFG_CYC+1 cycles here: the first one still shows the last
                // forwarded byte, leaving IFG_CYC low cycles after it.
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge gmii_txc or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            last_owner_q <= OWN_UDP;   // ARP wins the first tie
            cnt_q        <= '0;
            timeout_err  <= 1'b0;
            gmii_tx_en   <= 1'b0;
            gmii_txd     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            timeout_err  <= timeout_d;
            gmii_tx_en   <= mux_en;
            gmii_txd     <= mux_txd;
        end
    end

    // Start pulses decode registered state only, so reset clears them at once.
    assign arp_start = (state_q == ST_START) && (owner_q == OWN_ARP);
    assign udp_start = (state_q == ST_START) && (owner_q == OWN_UDP);
    assign owner     = owner_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Testbench for gmii_tx_arbiter: table rounds, randomized rounds against a
// transaction-level model, timeout and mid-frame reset sequences.
// Main instance uses the default timeout; a second instance uses TIMEOUT_CYC=16.
module tb_gmii_tx_arbiter;
    import eth_tx_pkg::*;

    localparam int IFG = 12;

    logic       gmii_txc = 1'b0;
    logic       rst;
    logic       arp_req, udp_req, arp_done, udp_done;
    logic       arp_gmii_tx_en, udp_gmii_tx_en;
    logic [7:0] arp_gmii_txd, udp_gmii_txd;

    logic       arp_start, udp_start, gmii_tx_en, busy, timeout_err;
    logic [7:0] gmii_txd;
    logic [1:0] owner;

    logic       to_arp_start, to_udp_start, to_gmii_tx_en, to_busy, to_timeout_err;
    logic [7:0] to_gmii_txd;
    logic [1:0] to_owner;

    int cyc    = 0;
    int checks = 0;
    int fails  = 0;
    bit mon_on = 1'b0;

    typedef struct { logic [7:0] d; int c; bit first; } exp_t;
    exp_t exp_q[$];

    typedef struct { int mode; int len; bit inc; bit gaps; logic [1:0] e1; logic [1:0] e2; } vec_t;
    vec_t tbl[8];

    logic [1:0] m_last;

    gmii_tx_arbiter #(.IFG_CYC(IFG), .TIMEOUT_CYC(2048), .CNT_W(12)) u_dut (
        .gmii_txc(gmii_txc), .rst(rst),
        .arp_req(arp_req), .udp_req(udp_req),
        .arp_start(arp_start), .udp_start(udp_start),
        .arp_done(arp_done), .udp_done(udp_done),
        .arp_gmii_tx_en(arp_gmii_tx_en), .arp_gmii_txd(arp_gmii_txd),
        .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd),
        .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    gmii_tx_arbiter #(.IFG_CYC(IFG), .TIMEOUT_CYC(16), .CNT_W(12)) u_dut_to (
        .gmii_txc(gmii_txc), .rst(rst),
        .arp_req(arp_req), .udp_req(udp_req),
        .arp_start(to_arp_start), .udp_start(to_udp_start),
        .arp_done(arp_done), .udp_done(udp_done),
        .arp_gmii_tx_en(arp_gmii_tx_en), .arp_gmii_txd(arp_gmii_txd),
        .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd),
        .gmii_tx_en(to_gmii_tx_en), .gmii_txd(to_gmii_txd),
        .owner(to_owner), .busy(to_busy), .timeout_err(to_timeout_err)
    );

    always #5 gmii_txc = ~gmii_txc;
    always @(posedge gmii_txc) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic set_eng(input bit is_arp, input logic en, input logic [7:0] d, input logic dn);
        if (is_arp) begin arp_gmii_tx_en = en; arp_gmii_txd = d; arp_done = dn; end
        else        begin udp_gmii_tx_en = en; udp_gmii_txd = d; udp_done = dn; end
    endtask

    task automatic set_done(input bit is_arp, input logic dn);
        if (is_arp) arp_done = dn; else udp_done = dn;
    endtask

    task automatic clear_engines();
        set_eng(1'b1, 1'b0, 8'd0, 1'b0);
        set_eng(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    // Scoreboard: every forwarded byte must match, arrive one cycle after it
    // was presented, and a new frame must follow >= IFG idle cycles.
    task automatic monitor();
        int   low_run;
        bit   seen;
        exp_t e;
        low_run = 0;
        seen    = 1'b0;
        forever begin
            @(negedge gmii_txc);
            if (!mon_on) begin
                low_run = 0;
                seen    = 1'b0;
            end else if (gmii_tx_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_byte actual=0x%0h required=none (cycle %0d)", gmii_txd, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_data", {24'd0, gmii_txd}, {24'd0, e.d});
                    chk("byte_latency", cyc, e.c + 1);
                    if (e.first && seen) chk("ifg_low_cycles", (low_run >= IFG) ? 1 : 0, 1);
                    seen = 1'b1;
                end
                low_run = 0;
            end else begin
                chk("txd_zero_when_idle", {24'd0, gmii_txd}, 0);
                low_run++;
            end
        end
    endtask

    task automatic wait_start(input string tag, output bit got_arp, output int s);
        got_arp = 1'b0;
        s = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge gmii_txc);
            if (arp_start || udp_start) begin
                got_arp = arp_start;
                s = cyc;
                break;
            end
        end
        if (s < 0) begin
            checks++;
            fails++;
            $display("FAIL %s actual=no_start required=start_pulse", tag);
        end
    endtask

    task automatic wait_idle(input string tag, output int ic);
        ic = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge gmii_txc);
            if (owner == 2'b00) begin
                ic = cyc;
                break;
            end
        end
        if (ic < 0) begin
            checks++;
            fails++;
            $display("FAIL %s actual=owner_stuck required=owner_00", tag);
        end
    endtask

    // Called in the START cycle. Engine bytes go out in XFER cycles 1..n with
    // done on the last byte. With gaps set, idle cycles are inserted, the
    // owner raises done during START and the other engine sends stray dones.
    task automatic drive_frame(input bit is_arp, input int len, input bit inc, input bit gaps,
                               output int lc, output int dc);
        int         sent;
        bit         first;
        logic       en;
        logic [7:0] d;
        sent  = 0;
        first = 1'b1;
        lc    = 0;
        if (gaps) set_done(is_arp, 1'b1);
        while (sent < len) begin
            @(negedge gmii_txc);
            lc++;
            if (lc == 1) chk("start_one_cycle", {30'd0, udp_start, arp_start}, 0);
            en = (!gaps || sent == 0 || sent == len - 1) ? 1'b1 : 1'(($urandom_range(0, 3) != 0));
            d  = inc ? 8'(sent + 1) : 8'($urandom);
            set_eng(is_arp, en, en ? d : 8'($urandom), en && (sent == len - 1));
            set_done(!is_arp, gaps ? 1'($urandom_range(0, 1)) : 1'b0);
            if (en) begin
                exp_q.push_back('{d, cyc, first});
                first = 1'b0;
                sent++;
            end
        end
        dc = cyc;
        @(negedge gmii_txc);
        clear_engines();
    endtask

    // mode: 1 ARP only, 2 UDP only, 3 both in the same cycle (both held).
    task automatic do_round(input string tag, input int mode, input int len, input bit inc,
                            input bit gaps, input logic [1:0] e1, input logic [1:0] e2);
        int r, s1, s2, lc, dc, ic;
        bit ga;
        @(negedge gmii_txc);
        arp_req = mode[0];
        udp_req = mode[1];
        r = cyc;
        wait_start({tag, "_start1"}, ga, s1);
        if (s1 < 0) begin
            arp_req = 1'b0;
            udp_req = 1'b0;
            return;
        end
        chk({tag, "_start1_cycle"}, s1, r + 1);
        chk({tag, "_start1_who"}, {30'd0, udp_start, arp_start}, {30'd0, e1});
        chk({tag, "_owner1"}, {30'd0, owner}, {30'd0, e1});
        chk({tag, "_busy_start"}, {31'd0, busy}, 1);
        if (ga) arp_req = 1'b0; else udp_req = 1'b0;
        drive_frame(ga, len, inc, gaps, lc, dc);
        if (e2 != 2'b00) begin
            wait_start({tag, "_start2"}, ga, s2);
            if (s2 < 0) begin
                arp_req = 1'b0;
                udp_req = 1'b0;
                return;
            end
            chk({tag, "_start2_cycle"}, s2, dc + IFG + 3);
            chk({tag, "_start2_who"}, {30'd0, udp_start, arp_start}, {30'd0, e2});
            chk({tag, "_owner2"}, {30'd0, owner}, {30'd0, e2});
            if (ga) arp_req = 1'b0; else udp_req = 1'b0;
            drive_frame(ga, len, inc, gaps, lc, dc);
        end
        wait_idle({tag, "_idle"}, ic);
        if (ic >= 0) begin
            chk({tag, "_idle_cycle"}, ic, dc + IFG + 2);
            chk({tag, "_busy_idle"}, {31'd0, busy}, 0);
        end
    endtask

    initial begin
        int         r, s, mode, len;
        bit         ga;
        logic [1:0] e1, e2;

        rst = 1'b1;
        arp_req = 1'b0;
        udp_req = 1'b0;
        clear_engines();
        fork
            monitor();
        join_none

        // Reset state of both instances.
        repeat (2) @(negedge gmii_txc);
        chk("rst_gmii_tx_en", {31'd0, gmii_tx_en}, 0);
        chk("rst_gmii_txd", {24'd0, gmii_txd}, 0);
        chk("rst_starts", {30'd0, udp_start, arp_start}, 0);
        chk("rst_owner", {30'd0, owner}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 0);
        chk("rst_to_outputs", {to_gmii_tx_en, to_gmii_txd, to_udp_start, to_arp_start,
                               to_owner, to_busy, to_timeout_err}, 0);
        @(negedge gmii_txc);
        rst = 1'b0;
        @(negedge gmii_txc);
        mon_on = 1'b1;

        // Hand-derived round-robin sequence starting from reset (last owner = UDP).
        tbl[0] = '{3,  8, 1'b0, 1'b0, OWN_ARP, OWN_UDP};
        tbl[1] = '{1, 60, 1'b1, 1'b0, OWN_ARP, OWN_NONE};
        tbl[2] = '{3, 12, 1'b0, 1'b1, OWN_UDP, OWN_ARP};
        tbl[3] = '{3,  5, 1'b0, 1'b0, OWN_UDP, OWN_ARP};
        tbl[4] = '{2,  7, 1'b0, 1'b1, OWN_UDP, OWN_NONE};
        tbl[5] = '{3,  9, 1'b0, 1'b1, OWN_ARP, OWN_UDP};
        tbl[6] = '{2,  3, 1'b1, 1'b0, OWN_UDP, OWN_NONE};
        tbl[7] = '{3,  4, 1'b1, 1'b0, OWN_ARP, OWN_UDP};
        for (int i = 0; i < 8; i++) begin
            do_round($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].len, tbl[i].inc, tbl[i].gaps,
                     tbl[i].e1, tbl[i].e2);
        end

        // Randomized rounds; the model only remembers who was served last.
        m_last = (tbl[7].e2 != 2'b00) ? tbl[7].e2 : tbl[7].e1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge gmii_txc);
            mode = $urandom_range(1, 3);
            len  = $urandom_range(2, 25);
            if (mode == 3) begin
                e1 = (m_last == OWN_UDP) ? OWN_ARP : OWN_UDP;
                e2 = (e1 == OWN_ARP) ? OWN_UDP : OWN_ARP;
            end else begin
                e1 = 2'(mode);
                e2 = OWN_NONE;
            end
            m_last = (e2 != 2'b00) ? e2 : e1;
            do_round($sformatf("rnd%0d", i), mode, len, 1'b0, 1'($urandom_range(0, 1)), e1, e2);
        end

        // Timeout on the TIMEOUT_CYC=16 instance: UDP streams forever, no done.
        @(negedge gmii_txc);
        mon_on = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge gmii_txc);
        rst = 1'b0;
        exp_q.delete();
        @(negedge gmii_txc);
        udp_req = 1'b1;
        r = cyc;
        s = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge gmii_txc);
            if (to_udp_start) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) begin
            checks++;
            fails++;
            $display("FAIL to_start actual=no_start required=start_pulse");
        end else begin
            chk("to_start_cycle", s, r + 1);
            udp_req = 1'b0;
            for (int k = 1; k <= 35; k++) begin
                @(negedge gmii_txc);
                udp_gmii_tx_en = 1'b1;
                udp_gmii_txd   = 8'(k);
                if (k == 5) arp_req = 1'b1;
                chk("to_err_pulse", {31'd0, to_timeout_err}, (cyc == s + 17) ? 1 : 0);
                if (cyc == s + 17) begin
                    chk("to_txen_last_byte", {31'd0, to_gmii_tx_en}, 1);
                    chk("to_txd_last_byte", {24'd0, to_gmii_txd}, 16);
                end
                if (cyc == s + 18) chk("to_txen_dropped", {31'd0, to_gmii_tx_en}, 0);
                if (cyc == s + 30) chk("to_owner_none", {30'd0, to_owner}, 0);
                if (cyc == s + 31) begin
                    chk("to_arp_served", {30'd0, to_udp_start, to_arp_start}, 1);
                    arp_req = 1'b0;
                end
            end
        end
        @(negedge gmii_txc);
        arp_req = 1'b0;
        clear_engines();
        rst = 1'b1;
        repeat (2) @(negedge gmii_txc);
        rst = 1'b0;
        @(negedge gmii_txc);
        mon_on = 1'b1;

        // Reset asserted at byte 20 of a UDP frame.
        @(negedge gmii_txc);
        udp_req = 1'b1;
        wait_start("mid_start", ga, s);
        udp_req = 1'b0;
        if (s >= 0) begin
            for (int k = 1; k <= 20; k++) begin
                @(negedge gmii_txc);
                set_eng(1'b0, 1'b1, 8'(k + 100), 1'b0);
                exp_q.push_back('{8'(k + 100), cyc, (k == 1)});
            end
            chk("mid_txen_before_rst", {31'd0, gmii_tx_en}, 1);
            mon_on = 1'b0;
            rst = 1'b1;
            #1;
            chk("mid_txen_async", {31'd0, gmii_tx_en}, 0);
            chk("mid_txd_async", {24'd0, gmii_txd}, 0);
            chk("mid_owner_async", {30'd0, owner}, 0);
            chk("mid_busy_async", {31'd0, busy}, 0);
            chk("mid_no_pulses", {29'd0, udp_start, arp_start, timeout_err}, 0);
        end
        clear_engines();
        exp_q.delete();
        @(negedge gmii_txc);
        rst = 1'b0;
        repeat (2) @(negedge gmii_txc);
        mon_on = 1'b1;
        // last_owner is back to UDP, so ARP wins this tie.
        do_round("post_rst", 3, 6, 1'b0, 1'b1, OWN_ARP, OWN_UDP);

        repeat (3) @(negedge gmii_txc);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
